// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the sequential 64-bit restoring divider and its
// subtract stage: default datapath width, iteration counter width and the
// divider FSM state encoding.
// -----------------------------------------------------------------------------
package div_pkg;

    // Operand / result width of the mantissa divide path.
    localparam int DIV_W = 64;

    // Iteration counter width: counts WIDTH-1 down to 0.
    localparam int DIV_CNT_W = $clog2(DIV_W);

    // Divider control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage : div_pkg

// File: rtl/seq_div64_sub64.sv
// -----------------------------------------------------------------------------
// sub64
// Purely combinational W-bit subtractor (default 64) computing a - b as
// a + ~b + 1 through a parallel-prefix generate/propagate (KGP) carry tree,
// so one divider iteration fits in a single clock cycle.
//
// Ports:
//   a_i      in  W  minuend
//   b_i      in  W  subtrahend
//   diff_o   out W  (a - b) modulo 2^W
//   borrow_o out 1  1 when a < b (inverse of the adder carry-out)
// -----------------------------------------------------------------------------
module sub64
    import div_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] diff_o,
    output logic         borrow_o
);

    localparam int LVL = $clog2(W);

    logic [W-1:0] b_n_s;
    logic [W-1:0] gen_s;
    logic [W-1:0] prop_s;

    // Group generate / propagate at each prefix level.
    logic [W-1:0] g_s [0:LVL];
    logic [W-1:0] p_s [0:LVL-1];

    assign b_n_s  = ~b_i;
    assign gen_s  = a_i & b_n_s;
    assign prop_s = a_i ^ b_n_s;

    // The carry-in of 1 is folded into bit 0's generate, so every group that
    // reaches bit 0 already accounts for it and needs no propagate term.
    assign g_s[0] = {gen_s[W-1:1], gen_s[0] | prop_s[0]};
    assign p_s[0] = prop_s;

    // Kogge-Stone style prefix: each level doubles the span of every group.
    // Bits shifted in from below are zero, which leaves groups that already
    // reach bit 0 unchanged.
    for (genvar l = 0; l < LVL; l++) begin : g_prefix
        localparam int SPAN = 2 ** l;
        assign g_s[l+1] = g_s[l] | (p_s[l] & (g_s[l] << SPAN));
        if (l < LVL - 1) begin : g_prop
            assign p_s[l+1] = p_s[l] & (p_s[l] << SPAN);
        end
    end

    // Carry into bit i is the group generate of bits [i-1:0]; bit 0 sees the carry-in.
    assign diff_o   = prop_s ^ {g_s[LVL][W-2:0], 1'b1};
    assign borrow_o = ~g_s[LVL][W-1];

endmodule : sub64

// File: rtl/seq_div64.sv
// -----------------------------------------------------------------------------
// seq_div64
// Sequential unsigned restoring divider, one quotient bit per clock. Operands
// are taken through a valid/ready handshake; the result is held in registers
// until the consumer accepts it. A zero divisor short-circuits to DONE with
// quotient = all ones, remainder = dividend and div_zero set.
//
// Ports:
//   clk        in   1      rising-edge clock
//   reset      in   1      asynchronous active-low reset
//   in_valid   in   1      operands present
//   in_ready   out  1      idle, able to accept operands
//   dividend   in   WIDTH  unsigned numerator
//   divisor    in   WIDTH  unsigned denominator
//   out_valid  out  1      result valid, held until accepted
//   out_ready  in   1      consumer accepts the result
//   quotient   out  WIDTH  registered quotient
//   remainder  out  WIDTH  registered remainder
//   div_zero   out  1      result came from a divide by zero
// -----------------------------------------------------------------------------
module seq_div64
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int CNT_W = $clog2(WIDTH);

    // WIDTH is a power of two, so WIDTH-1 is the all-ones count value.
    localparam logic [CNT_W-1:0] CNT_LAST = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    div_state_t       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] quo_q;        // working quotient / remaining dividend bits
    logic [WIDTH-1:0] rem_q;        // partial remainder
    logic [WIDTH-1:0] den_q;        // captured divisor
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             div_zero_q;
    logic             out_valid_q;

    logic [WIDTH-1:0] trial_s;
    logic [WIDTH-1:0] diff_s;
    logic             borrow_s;
    logic             take_s;
    logic [WIDTH-1:0] quo_d;
    logic [WIDTH-1:0] rem_d;

    // Low WIDTH bits of the shifted partial remainder; rem_q[WIDTH-1] is the
    // kept 65th bit and is handled in the take decision below.
    assign trial_s = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};

    sub64 #(
        .W (WIDTH)
    ) u_sub64 (
        .a_i      (trial_s),
        .b_i      (den_q),
        .diff_o   (diff_s),
        .borrow_o (borrow_s)
    );

    // Restoring step: subtract when the 65-bit trial value is >= divisor.
    // With the top bit set the trial exceeds any divisor, and the low WIDTH
    // bits of the difference are exact because the result is < divisor.
    always_comb begin
        take_s = rem_q[WIDTH-1] | ~borrow_s;
        quo_d  = {quo_q[WIDTH-2:0], take_s};
        if (take_s) begin
            rem_d = diff_s;
        end else begin
            rem_d = trial_s;
        end
    end

    // Divider FSM with datapath registers and registered result outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            den_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        if (divisor == '0) begin
                            state_q     <= DONE;
                            quotient_q  <= '1;
                            remainder_q <= dividend;
                            div_zero_q  <= 1'b1;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= RUN;
                            quo_q   <= dividend;
                            rem_q   <= '0;
                            den_q   <= divisor;
                            cnt_q   <= CNT_LAST;
                        end
                    end
                end
                RUN: begin
                    quo_q <= quo_d;
                    rem_q <= rem_d;
                    if (cnt_q == '0) begin
                        state_q     <= DONE;
                        quotient_q  <= quo_d;
                        remainder_q <= rem_d;
                        div_zero_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // in_ready depends only on the state register, never on in_valid.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign div_zero  = div_zero_q;

endmodule : seq_div64

// File: tb/tb_seq_div64.sv
// -----------------------------------------------------------------------------
// tb_seq_div64
// Directed and small random bench for seq_div64. Inputs are driven and
// outputs sampled 1 time unit after the rising clock edge.
// -----------------------------------------------------------------------------
module tb_seq_div64;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MSB  = 64'h8000_0000_0000_0000;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] dividend;
    logic [63:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] quotient;
    logic [63:0] remainder;
    logic        div_zero;

    int errors;
    int checks;

    seq_div64 dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present operands, let them be accepted, scramble the inputs afterwards
    // and wait for out_valid. lat counts edges after the accepting edge.
    task automatic do_div(input logic [63:0] a, input logic [63:0] b,
                          output logic [63:0] q, output logic [63:0] r,
                          output logic dz, output int lat);
        int w;
        w = 0;
        while (!in_ready && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        dividend = ~a;
        divisor  = b + 64'd3;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            $display("FAIL wait_out_valid: out_valid=%b after %0d cycles, required 1", out_valid, lat);
            errors++;
        end
        q  = quotient;
        r  = remainder;
        dz = div_zero;
    endtask

    task automatic accept();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = 64'd0;
        divisor   = 64'd0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            $display("FAIL reset_in_ready: got %b required 1", in_ready); errors++;
        end
        checks++;
        if (out_valid !== 1'b0) begin
            $display("FAIL reset_out_valid: got %b required 0", out_valid); errors++;
        end
        checks++;
        if (quotient !== 64'd0 || remainder !== 64'd0) begin
            $display("FAIL reset_results: q=%h r=%h required 0 0", quotient, remainder); errors++;
        end
        checks++;
        if (div_zero !== 1'b0) begin
            $display("FAIL reset_div_zero: got %b required 0", div_zero); errors++;
        end
        reset = 1'b1;
    endtask

    task automatic test_basic();
        logic [63:0] q, r;
        logic        dz;
        int          lat;
        do_div(64'd100, 64'd7, q, r, dz, lat);
        checks++;
        if (q !== 64'd14 || r !== 64'd2 || dz !== 1'b0) begin
            $display("FAIL basic_100_7: q=%0d r=%0d dz=%b required 14 2 0", q, r, dz); errors++;
        end
        checks++;
        if (lat !== 64) begin
            $display("FAIL basic_latency: got %0d required 64", lat); errors++;
        end
        accept();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            $display("FAIL basic_accept: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready); errors++;
        end
    endtask

    task automatic test_extremes();
        logic [63:0] va [5];
        logic [63:0] vb [5];
        logic [63:0] vq [5];
        logic [63:0] vr [5];
        logic [63:0] q, r;
        logic        dz;
        int          lat;
        va[0] = ONES;    vb[0] = 64'd1;  vq[0] = ONES;                   vr[0] = 64'd0;
        va[1] = ONES;    vb[1] = MSB;    vq[1] = 64'd1;                  vr[1] = 64'h7FFF_FFFF_FFFF_FFFF;
        va[2] = 64'd5;   vb[2] = 64'd9;  vq[2] = 64'd0;                  vr[2] = 64'd5;
        va[3] = ONES;    vb[3] = ONES;   vq[3] = 64'd1;                  vr[3] = 64'd0;
        va[4] = MSB;     vb[4] = 64'd3;  vq[4] = 64'h2AAA_AAAA_AAAA_AAAA; vr[4] = 64'd2;
        for (int i = 0; i < 5; i++) begin
            do_div(va[i], vb[i], q, r, dz, lat);
            checks++;
            if (q !== vq[i] || r !== vr[i] || dz !== 1'b0) begin
                $display("FAIL extreme_%0d: q=%h r=%h dz=%b required %h %h 0", i, q, r, dz, vq[i], vr[i]);
                errors++;
            end
            accept();
        end
    endtask

    task automatic test_div_zero();
        logic [63:0] q, r;
        logic        dz;
        int          lat;
        do_div(64'h1234, 64'd0, q, r, dz, lat);
        checks++;
        if (q !== ONES || r !== 64'h1234 || dz !== 1'b1) begin
            $display("FAIL div_zero_result: q=%h r=%h dz=%b required all-ones 1234 1", q, r, dz); errors++;
        end
        // out_valid must already be high in the cycle after the accepting edge.
        checks++;
        if (lat !== 0) begin
            $display("FAIL div_zero_latency: got %0d extra cycles required 0", lat); errors++;
        end
        accept();
    endtask

    task automatic test_backpressure();
        logic [63:0] q, r;
        logic        dz;
        int          lat;
        do_div(64'd1000, 64'd3, q, r, dz, lat);
        checks++;
        if (q !== 64'd333 || r !== 64'd1 || dz !== 1'b0) begin
            $display("FAIL bp_result: q=%0d r=%0d dz=%b required 333 1 0", q, r, dz); errors++;
        end
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            dividend = 64'd50;
            divisor  = 64'd5;
            @(posedge clk); #1;
            checks++;
            if (quotient !== 64'd333 || remainder !== 64'd1 || out_valid !== 1'b1) begin
                $display("FAIL bp_hold_%0d: q=%0d r=%0d out_valid=%b required 333 1 1", i, quotient, remainder, out_valid);
                errors++;
            end
            checks++;
            if (in_ready !== 1'b0) begin
                $display("FAIL bp_in_ready_%0d: got %b required 0", i, in_ready); errors++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            $display("FAIL bp_accept: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready); errors++;
        end
        // Next divide must be accepted on the very next edge.
        dividend = 64'd81;
        divisor  = 64'd9;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            $display("FAIL bp_next_accept: in_ready=%b required 0", in_ready); errors++;
        end
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat !== 64 || quotient !== 64'd9 || remainder !== 64'd0) begin
            $display("FAIL bp_next_result: lat=%0d q=%0d r=%0d required 64 9 0", lat, quotient, remainder); errors++;
        end
        accept();
    endtask

    task automatic test_reset_mid_run();
        logic [63:0] q, r;
        logic        dz;
        int          lat;
        dividend = 64'd12345;
        divisor  = 64'd67;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (30) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            $display("FAIL midrun_handshake: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready); errors++;
        end
        checks++;
        if (quotient !== 64'd0 || remainder !== 64'd0 || div_zero !== 1'b0) begin
            $display("FAIL midrun_outputs: q=%h r=%h dz=%b required 0 0 0", quotient, remainder, div_zero); errors++;
        end
        @(posedge clk); #1;
        reset = 1'b1;
        do_div(64'd81, 64'd9, q, r, dz, lat);
        checks++;
        if (q !== 64'd9 || r !== 64'd0 || dz !== 1'b0 || lat !== 64) begin
            $display("FAIL midrun_fresh: q=%0d r=%0d dz=%b lat=%0d required 9 0 0 64", q, r, dz, lat); errors++;
        end
        accept();
    endtask

    task automatic test_random();
        logic [63:0] a, b, q, r;
        logic        dz;
        int          lat;
        for (int i = 0; i < 150; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom} >> $urandom_range(0, 63);
            if ((i % 4) == 0) a = a >> $urandom_range(0, 63);
            if (b == 64'd0) b = 64'd1;
            do_div(a, b, q, r, dz, lat);
            checks++;
            if (q !== a / b || r !== a % b || dz !== 1'b0) begin
                $display("FAIL random_%0d: %h/%h q=%h r=%h required %h %h", i, a, b, q, r, a / b, a % b);
                errors++;
            end
            accept();
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_basic();
        test_extremes();
        test_div_zero();
        test_backpressure();
        test_reset_mid_run();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_seq_div64

// File: doc/seq_div64.md
# seq_div64

Sequential 64-bit unsigned restoring divider for the FMUL/FDIV datapath. It is the inverse companion of the 64-bit lookahead adder: it repeatedly subtracts with a 64-bit subtract stage to produce a quotient and remainder, one bit per cycle. The block takes operands through a valid/ready handshake and holds its result until the consumer accepts it. The mantissa divide path of the floating-point unit instantiates it.

## Interface
- `WIDTH`, 64, operand/result width. Only 64 is verified.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `in_valid`  in  1  operands present.
- `in_ready`  out  1  divider idle and able to accept operands.
- `dividend`  in  WIDTH  unsigned numerator.
- `divisor`  in  WIDTH  unsigned denominator.
- `out_valid`  out  1  result valid; held until accepted.
- `out_ready`  in  1  consumer accepts the result.
- `quotient`  out  WIDTH  registered quotient.
- `remainder`  out  WIDTH  registered remainder.
- `div_zero`  out  1  the result came from a divide by zero.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - RUN: iterate.
  - DONE: `out_valid`=1.
- IDLE→RUN on `in_valid & in_ready` with `divisor`≠0.
  - Load Q←dividend, R←0, D←divisor, count←WIDTH-1.
- IDLE→DONE on acceptance with `divisor`=0.
  - quotient←all ones, remainder←dividend, `div_zero`←1.
- RUN, each cycle:
  - Form T = {R[WIDTH-2:0], Q[WIDTH-1]} with the 65th bit R[WIDTH-1] kept.
  - Compute T − D in `sub64`, including borrow.
  - If no borrow (or the kept top bit is 1): R←T−D and shift 1 into Q. Otherwise R←T and shift 0 into Q.
  - Decrement count. At count=0, go to DONE.
- DONE: `quotient`/`remainder`/`div_zero` are stable. Go to IDLE on `out_ready`.
- All arithmetic is unsigned and modulo 2^WIDTH.
  - The shifted partial remainder is WIDTH+1 bits, so it never overflows.
  - Invariant: dividend = quotient·divisor + remainder, with remainder < divisor.
- Operands are sampled only on the accepting edge. Later changes on `dividend`/`divisor` are ignored.
- `in_valid` while busy is not accepted. The upstream holds its operands.
- `out_ready` outside DONE has no effect.

## Timing
- Reset (asynchronous assert, any state, including mid-RUN):
  - State←IDLE.
  - `out_valid`=0, `quotient`=0, `remainder`=0, `div_zero`=0, count=0.
  - `in_ready`=1 (decoded from state).
- Deassertion is synchronised to `clk` by the top level. The block accepts operands on the first edge after deassertion.
- Latency, divisor≠0:
  - Operands accepted at edge N.
  - RUN occupies edges N+1…N+64.
  - `out_valid` rises after edge N+64, i.e. 64 cycles after acceptance.
- Latency, divisor=0: `out_valid` high 1 cycle after acceptance.
- Result accepted at edge M (`out_valid & out_ready`): `out_valid`=0 and `in_ready`=1 after M.
  - Next acceptance at M+1 at the earliest. Throughput is one divide per 66 cycles when downstream is always ready.
- No combinational path from `in_valid` to `in_ready`, or from `out_ready` to `out_valid`.

## Structure
- Shared package `div_pkg`:
  - `DIV_W`=64.
  - State enum `div_state_t` {IDLE, RUN, DONE}.
  - Count width `$clog2(DIV_W)`.
- One sub-module, `sub64`: computes a−b, returning diff[63:0] and borrow.
  - Built on the team's existing KGP/lookahead carry cells, with b inverted and carry-in = 1.
  - Purely combinational, so one iteration completes per cycle.
- The top holds the FSM, count, Q/R/D registers and handshake. Target 150–250 lines of RTL.

## Test plan
- Basic divide: dividend=100, divisor=7.
  - quotient=14, remainder=2, `div_zero`=0.
  - `out_valid` exactly 64 cycles after acceptance.
- Extremes: dividend=0xFFFF_FFFF_FFFF_FFFF.
  - divisor=1 → quotient=all ones, remainder=0.
  - divisor=0x8000_0000_0000_0000 → quotient=1, remainder=0x7FFF_FFFF_FFFF_FFFF. This exercises the 65th bit.
- Divide by zero: dividend=0x1234, divisor=0.
  - After 1 cycle: quotient=all ones, remainder=0x1234, `div_zero`=1.
- Backpressure: `out_ready`=0 for 10 cycles after `out_valid` rises.
  - Results stay stable and `in_ready` stays 0.
  - `in_valid` pulses during that time are not accepted.
  - After acceptance, the next divide starts at the following edge.
- Reset mid-RUN: assert `reset`=0 at iteration 30.
  - Outputs go 0 immediately and `in_ready`=1.
  - After release, a fresh divide of 81/9 gives quotient=9, remainder=0.
- Random regression: 10k random operand pairs, including divisor > dividend (quotient=0, remainder=dividend).
  - Check the invariant against a reference model.
